fila_drain: RTL and testbench

Downstream drain controller for the 8-bit queue (`fila`). It watches the queue's length and issues single-cycle dequeue pulses. It captures each popped byte and presents it to a consumer over a valid/ready handshake. It never pops a new item while an undelivered byte is held, so no data is lost under backpressure.

---
 rtl/fila_drain.sv | 99 +++++++++
 tb/tb_fila_drain.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fila_drain.sv
// Drain controller for the fila queue: pops one byte at a time and offers it on valid/ready.
// Latency: first byte is valid POP_LATENCY+1 edges after the dequeue pulse; pops repeat every POP_LATENCY+2 cycles.
// Backpressure: a held byte blocks further pops until ready_in accepts it, so nothing is dropped.
module fila_drain #(
    parameter int DATA_W      = 8,
    parameter int LEN_W       = 8,
    parameter int POP_LATENCY = 1
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [LEN_W-1:0]  count_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(POP_LATENCY - 1);

    state_t            state, state_nxt;
    logic [1:0]        wait_cnt, wait_nxt;
    logic              deq_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              vld_nxt;
    logic [LEN_W-1:0]  cnt_nxt;

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 2'd0;
            dequeue_out <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            count_out   <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            dequeue_out <= deq_nxt;
            data_out    <= data_nxt;
            valid_out   <= vld_nxt;
            count_out   <= cnt_nxt;
        end
    end

    // dequeue_out is registered, so it is raised on the edge that enters POP.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        deq_nxt   = 1'b0;
        data_nxt  = data_out;
        vld_nxt   = valid_out;
        cnt_nxt   = count_out;
        case (state)
            IDLE: begin
                if (len_in != '0) begin
                    state_nxt = POP;
                    deq_nxt   = 1'b1;
                end
            end
            POP: begin
                wait_nxt  = WAIT_INIT;
                state_nxt = WAIT;
            end
            WAIT: begin
                // len_in is still settling here; only the latency counter matters.
                if (wait_cnt == 2'd0) begin
                    data_nxt  = data_in;
                    vld_nxt   = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    wait_nxt = wait_cnt - 2'd1;
                end
            end
            HOLD: begin
                if (ready_in) begin
                    vld_nxt = 1'b0;
                    cnt_nxt = count_out + LEN_W'(1);
                    if (len_in != '0) begin
                        state_nxt = POP;
                        deq_nxt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fila_drain.sv
// Directed bench for fila_drain with a latency-1 queue model feeding len_in/data_in.
module tb_fila_drain;

    logic       clk_10KHz = 1'b0;
    logic       reset;
    logic       ready_in;
    logic [7:0] len_in;
    logic [7:0] data_in = 8'h00;
    logic       dequeue_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic [7:0] count_out;

    logic [7:0] mem [256];
    logic [7:0] head = 8'h00;
    logic [7:0] tail = 8'h00;
    assign len_in = tail - head;

    int n_cmp = 0;
    int n_bad = 0;
    int rule_viol = 0;
    int underflow = 0;
    logic [7:0] got [$];
    logic       prev_deq = 1'b0;
    logic       prev_vld = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always #5 clk_10KHz = ~clk_10KHz;

    fila_drain #(.DATA_W(8), .LEN_W(8), .POP_LATENCY(1)) dut (
        .clk_10KHz  (clk_10KHz),
        .reset      (reset),
        .len_in     (len_in),
        .data_in    (data_in),
        .dequeue_out(dequeue_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .count_out  (count_out)
    );

    // Queue model: a dequeue sampled at an edge presents the head byte after that edge.
    always @(posedge clk_10KHz) begin
        if (dequeue_out) begin
            data_in <= mem[head];
            head    <= head + 8'd1;
        end
    end

    always @(negedge clk_10KHz) begin
        if (dequeue_out && prev_deq) rule_viol++;
        if (dequeue_out && valid_out) rule_viol++;
        if (dequeue_out && len_in == 8'd0) underflow++;
        if (prev_vld && valid_out && data_out !== prev_dat) rule_viol++;
        if (valid_out && ready_in && !reset) got.push_back(data_out);
        prev_deq = dequeue_out;
        prev_vld = valid_out;
        prev_dat = data_out;
    end

    task automatic tick();
        @(posedge clk_10KHz);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        mem[tail] = b;
        tail = tail + 8'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
        repeat (2) begin
            tick();
            n_cmp++;
            if ({dequeue_out, valid_out, data_out, count_out} !== 18'h0) begin
                n_bad++;
                $display("FAIL reset_outputs: got deq=%b vld=%b dat=%h cnt=%h expected all zero",
                         dequeue_out, valid_out, data_out, count_out);
            end
        end
        tail = head;
        reset = 1'b0;
    endtask

    task automatic test_empty();
        ready_in = 1'b1;
        repeat (20) begin
            tick();
            n_cmp++;
            if ({dequeue_out, valid_out} !== 2'b00) begin
                n_bad++;
                $display("FAIL empty_no_pop: got deq=%b vld=%b expected 0 0", dequeue_out, valid_out);
            end
        end
    endtask

    task automatic test_single();
        int extra;
        ready_in = 1'b1;
        load(8'h11);
        tick();
        n_cmp++;
        if (dequeue_out !== 1'b1) begin
            n_bad++;
            $display("FAIL single_pop: got deq=%b expected 1", dequeue_out);
        end
        tick();
        n_cmp++;
        if ({dequeue_out, valid_out} !== 2'b00) begin
            n_bad++;
            $display("FAIL single_wait: got deq=%b vld=%b expected 0 0", dequeue_out, valid_out);
        end
        tick();
        n_cmp++;
        if ({valid_out, data_out} !== {1'b1, 8'h11}) begin
            n_bad++;
            $display("FAIL single_capture: got vld=%b dat=%h expected 1 11", valid_out, data_out);
        end
        tick();
        n_cmp++;
        if ({valid_out, count_out} !== {1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL single_handshake: got vld=%b cnt=%0d expected 0 1", valid_out, count_out);
        end
        extra = 0;
        repeat (5) begin
            tick();
            if (dequeue_out) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL single_idle: got %0d extra pops expected 0", extra);
        end
    endtask

    task automatic test_burst();
        int base, pops, last;
        base = got.size();
        pops = 0;
        last = -1;
        ready_in = 1'b1;
        for (int i = 1; i <= 8; i++) load(8'(i * 8'h11));
        for (int c = 0; c < 60; c++) begin
            tick();
            if (dequeue_out) begin
                if (pops > 0) begin
                    n_cmp++;
                    if (c - last != 3) begin
                        n_bad++;
                        $display("FAIL burst_spacing: got %0d cycles expected 3", c - last);
                    end
                end
                last = c;
                pops++;
            end
        end
        n_cmp++;
        if (pops != 8) begin
            n_bad++;
            $display("FAIL burst_pops: got %0d expected 8", pops);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got.size() <= base + i || got[base + i] !== 8'((i + 1) * 8'h11)) begin
                n_bad++;
                $display("FAIL burst_order[%0d]: got %h expected %h", i,
                         (got.size() > base + i) ? got[base + i] : 8'hxx, 8'((i + 1) * 8'h11));
            end
        end
        // One byte from the single-item test plus eight from this burst.
        n_cmp++;
        if ({count_out, len_in} !== {8'd9, 8'd0}) begin
            n_bad++;
            $display("FAIL burst_count: got cnt=%0d len=%0d expected 9 0", count_out, len_in);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        ready_in = 1'b0;
        load(8'h22);
        for (int i = 0; i < 5; i++) load(8'h30 + 8'(i));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = valid_out;
        end
        n_cmp++;
        if (!seen || data_out !== 8'h22 || len_in !== 8'd5) begin
            n_bad++;
            $display("FAIL bp_capture: got vld=%b dat=%h len=%0d expected 1 22 5", valid_out, data_out, len_in);
        end
        repeat (10) begin
            tick();
            n_cmp++;
            if ({valid_out, data_out, dequeue_out} !== {1'b1, 8'h22, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold: got vld=%b dat=%h deq=%b expected 1 22 0", valid_out, data_out, dequeue_out);
            end
        end
        ready_in = 1'b1;
        tick();
        n_cmp++;
        if ({valid_out, dequeue_out, count_out} !== {1'b0, 1'b1, 8'd10}) begin
            n_bad++;
            $display("FAIL bp_release: got vld=%b deq=%b cnt=%0d expected 0 1 10", valid_out, dequeue_out, count_out);
        end
        repeat (20) tick();
        n_cmp++;
        if ({count_out, len_in, valid_out} !== {8'd15, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_drain: got cnt=%0d len=%0d vld=%b expected 15 0 0", count_out, len_in, valid_out);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit seen;
        int pops;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready_in = 1'b1;
        load(8'h41); load(8'h42); load(8'h43);
        repeat (12) tick();
        n_cmp++;
        if (count_out !== 8'd3) begin
            n_bad++;
            $display("FAIL mid_precount: got %0d expected 3", count_out);
        end
        ready_in = 1'b0;
        load(8'h44);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = valid_out;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL mid_hold: got vld=0 expected 1");
        end
        // Reset and ready together: reset must win.
        reset = 1'b1;
        ready_in = 1'b1;
        tick();
        n_cmp++;
        if ({valid_out, count_out, dequeue_out} !== 10'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got vld=%b cnt=%0d deq=%b expected 0 0 0", valid_out, count_out, dequeue_out);
        end
        reset = 1'b0;
        pops = 0;
        repeat (4) begin
            tick();
            if (dequeue_out) pops++;
        end
        n_cmp++;
        if (pops != 0) begin
            n_bad++;
            $display("FAIL mid_idle: got %0d pops expected 0", pops);
        end
        load(8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = valid_out;
        end
        n_cmp++;
        if (!seen || data_out !== 8'h5A) begin
            n_bad++;
            $display("FAIL mid_resume: got vld=%b dat=%h expected 1 5a", valid_out, data_out);
        end
        tick();
        n_cmp++;
        if ({valid_out, count_out} !== {1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL mid_resume_cnt: got vld=%b cnt=%0d expected 0 1", valid_out, count_out);
        end
    endtask

    task automatic test_wrap();
        int base;
        bit done;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready_in = 1'b1;
        base = got.size();
        for (int i = 0; i < 128; i++) load(8'(i));
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            tick();
            done = (count_out == 8'd128);
        end
        n_cmp++;
        if (count_out !== 8'd128) begin
            n_bad++;
            $display("FAIL wrap_half: got %0d expected 128", count_out);
        end
        for (int i = 128; i < 256; i++) load(8'(i));
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            tick();
            done = (got.size() - base == 256) && !valid_out && !dequeue_out;
        end
        n_cmp++;
        if (!done || count_out !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap_count: got cnt=%0d delivered=%0d expected 0 256", count_out, got.size() - base);
        end
        n_cmp++;
        if (got.size() < base + 256 || got[base + 255] !== 8'hFF || got[base + 128] !== 8'h80) begin
            n_bad++;
            $display("FAIL wrap_data: got size=%0d expected last bytes 80..ff in order", got.size() - base);
        end
    endtask

    task automatic test_rules();
        n_cmp++;
        if (rule_viol != 0) begin
            n_bad++;
            $display("FAIL rule_monitor: got %0d violations expected 0", rule_viol);
        end
        n_cmp++;
        if (underflow != 0) begin
            n_bad++;
            $display("FAIL empty_pop: got %0d pops on empty queue expected 0", underflow);
        end
    endtask

    initial begin
        reset = 1'b1;
        ready_in = 1'b0;
        test_reset();
        test_empty();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid_hold();
        test_wrap();
        test_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
